// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Instruction-memory read handshake (one outstanding request).
// Revision    : 1.0
// ============================================================================
interface fetch_stage_if #(
  parameter int WIDTH = 32
);
  logic             imem_read;
  logic [WIDTH-1:0] imem_address;
  logic [WIDTH-1:0] imem_rdata;
  logic             imem_resp;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_rdata,
    input  imem_resp
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_rdata,
    output imem_resp
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I fetch stage with PC, one-entry skid buffer and redirect.
// Revision    : 1.0
// ============================================================================
module fetch_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0060,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             stall_i,
  input  wire logic             flush_i,
  input  wire logic [WIDTH-1:0] redirect_pc_i,
  fetch_stage_if.master         imem,
  output logic      [WIDTH-1:0] IF_instr_o,
  output logic      [WIDTH-1:0] IF_pc_out_o,
  output logic                  IF_valid_o
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_drop_addr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_instr;
  logic [WIDTH-1:0] r_out_pc;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_instr;
  logic [WIDTH-1:0] r_skid_pc;

  logic             w_slot_free;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_redirect;

  assign w_slot_free = !r_out_valid || !stall_i;
  assign w_pc_next   = r_pc + WIDTH'(4);
  assign w_redirect  = redirect_pc_i & ~(WIDTH'(3));

  // Read is gated by reset directly so it drops the moment reset asserts
  // and rises in the very cycle reset is released.
  assign imem.imem_read    = rst && (r_state != ST_HOLD);
  assign imem.imem_address = (r_state == ST_DROP) ? r_drop_addr : r_pc;

  assign IF_valid_o  = r_out_valid;
  assign IF_instr_o  = r_out_instr;
  assign IF_pc_out_o = r_out_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_drop_addr  <= '0;
      r_out_valid  <= 1'b0;
      r_out_instr  <= NOP_INSTR;
      r_out_pc     <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= '0;
    end else if (flush_i) begin
      r_out_valid  <= 1'b0;
      r_out_instr  <= NOP_INSTR;
      r_skid_valid <= 1'b0;
      r_pc         <= w_redirect;
      case (r_state)
        ST_FETCH: begin
          // An unanswered request must be drained at its original address.
          if (!imem.imem_resp) begin
            r_state     <= ST_DROP;
            r_drop_addr <= r_pc;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        ST_DROP: begin
          if (imem.imem_resp) r_state <= ST_FETCH;
        end
        default: r_state <= ST_FETCH;
      endcase
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem.imem_resp) begin
            r_pc <= w_pc_next;
            if (w_slot_free) begin
              r_out_valid <= 1'b1;
              r_out_instr <= imem.imem_rdata;
              r_out_pc    <= r_pc;
            end else begin
              r_skid_valid <= 1'b1;
              r_skid_instr <= imem.imem_rdata;
              r_skid_pc    <= r_pc;
              r_state      <= ST_HOLD;
            end
          end else if (w_slot_free) begin
            r_out_valid <= 1'b0;
            r_out_instr <= NOP_INSTR;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            r_out_valid  <= r_skid_valid;
            r_out_instr  <= r_skid_valid ? r_skid_instr : NOP_INSTR;
            r_out_pc     <= r_skid_pc;
            r_skid_valid <= 1'b0;
            r_state      <= ST_FETCH;
          end
        end
        ST_DROP: begin
          if (imem.imem_resp) r_state <= ST_FETCH;
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the five-stage RV32I pipeline. Owns the program counter, fetches instruction words over the instruction-memory handshake, and presents each instruction with its PC to the IF/ID register for decode. Honours pipeline stalls from the hazard detector and PC redirects from branch/jump resolution. A one-entry skid buffer ensures that no returned word is lost or duplicated.

## Interface
- `width`, 32, datapath and address width
- `RESET_PC`, 32'h0000_0060, first fetch address after reset
- `NOP_INSTR`, 32'h0000_0013, word driven on `IF_instr_o` when no valid instruction (`addi x0,x0,0`)

- `clk`  in  1  pipeline clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `stall_i`  in  1  IF/ID must hold; output not consumed this cycle
- `flush_i`  in  1  redirect fetch; kill buffered and in-flight instructions
- `redirect_pc_i`  in  width  new fetch PC, sampled when `flush_i`=1
- `imem_read`  out  1  instruction read request
- `imem_address`  out  width  request address, word aligned
- `imem_rdata`  in  width  instruction word, valid only when `imem_resp`=1
- `imem_resp`  in  1  single-cycle completion pulse for the outstanding read
- `IF_instr_o`  out  width  instruction to IF/ID
- `IF_pc_out_o`  out  width  PC of `IF_instr_o`
- `IF_valid_o`  out  1  `IF_instr_o`/`IF_pc_out_o` hold a live instruction

## Operation
- State: `pc_q` (next fetch address); output register {valid, instr, pc}; skid register {valid, instr, pc}; FSM in {FETCH, HOLD, DROP}.
- Consume condition: output consumed when `IF_valid_o`=1 and `stall_i`=0. Output slot free when `IF_valid_o`=0 or consumed.
- FETCH: `imem_read`=1, `imem_address`=`pc_q`.
  - On `imem_resp`, slot free, no flush: output <= {1, `imem_rdata`, `pc_q`}; `pc_q` += 4; stay FETCH.
  - On `imem_resp`, slot not free, no flush: skid <= {1, rdata, `pc_q`}; `pc_q` += 4; go to HOLD.
  - No resp, slot free: output valid <= 0 (bubble).
- HOLD: `imem_read`=0. When `stall_i`=0: output <= skid, skid valid <= 0, go to FETCH.
- DROP: `imem_read`=1, `imem_address` = address of the killed request (held stable). On `imem_resp`: discard the word and go to FETCH.
- Flush, highest priority, ignores `stall_i`:
  - Clear output valid and skid valid.
  - `pc_q` <= {`redirect_pc_i`[31:2], 2'b00}.
  - Next state:
    - DROP if in FETCH with no `imem_resp` this cycle.
    - FETCH if `imem_resp` arrives this cycle (word discarded), or if in HOLD.
    - Flush in DROP: update `pc_q` and remain in DROP.
- When output valid=0: `IF_instr_o`=`NOP_INSTR`, `IF_pc_out_o` holds its last value.
- PC arithmetic is modulo 2^width; 32'hFFFF_FFFC + 4 wraps to 0.
- At most one memory request outstanding. Address is never changed while `imem_read`=1 until `imem_resp`.

## Timing
- Reset (async assert):
  - FSM=FETCH, `pc_q`=`RESET_PC`.
  - Output and skid valid=0; `IF_instr_o`=`NOP_INSTR`; `IF_pc_out_o`=0.
  - `imem_read` forced 0 while `rst`=0.
- First `imem_read`=1 in the first cycle after `rst` deasserts.
- Latency: `imem_resp` in cycle N puts the instruction on `IF_valid_o` in cycle N+1.
- Throughput with zero-wait memory (resp in request cycle): one instruction per cycle.
- Stall: outputs registered and held bit-exact while `stall_i`=1.
- Flush in cycle N:
  - `IF_valid_o`=0 in N+1.
  - First request to the redirect PC in N+1 if no in-flight request, else the cycle after the pending `imem_resp`.
- Reset mid-request abandons the request. The memory side must tolerate dropping `imem_read` before `imem_resp`.

## Test plan
- Reset: `rst`=0 → `imem_read`=0, `IF_valid_o`=0, `IF_instr_o`=0x13, `IF_pc_out_o`=0. Release → `imem_read`=1, `imem_address`=0x60 the same cycle.
- Zero-wait stream, `imem_rdata`=address each cycle → `IF_pc_out_o`/`IF_instr_o` = 0x60, 0x64, 0x68, 0x6C on consecutive cycles, `IF_valid_o` continuously 1.
- `stall_i`=1 for 3 cycles while output 0x64 is valid and resp for 0x68 arrives:
  - Output holds 0x64; skid takes 0x68; `imem_read`=0 in HOLD.
  - After stall drop: 0x68 appears next cycle, then request 0x6C. No duplicates or losses.
- Request 0x64 pending with 2-cycle memory latency; `flush_i`=1 with `redirect_pc_i`=0x203:
  - `imem_address` stays 0x64 until resp and the word is discarded.
  - Next request is 0x200; 0x64 never appears with `IF_valid_o`=1.
- `flush_i`, `stall_i` and `imem_resp` all in the same cycle with redirect 0x100 → `IF_valid_o`=0 next cycle, next request 0x100.
- `rst` asserted during a 3-cycle memory wait → `imem_read` drops immediately. After release, fetch restarts at 0x60 and the stale response is ignored.
